// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: IDLE -> REQ -> VALID loop with a bounded wait for IMemAck
// and a sticky HALT on timeout. Define PC_ALIGN_CHECK_EN to also halt on a misaligned NextPC.
module pc_fetch_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic [63:0] startPC,
  input  logic [63:0] NextPC,
  input  logic        Stall,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [63:0] CurrentPC,
  output logic        IMemReq,
  output logic [63:0] IMemAddr,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic        Fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_next;
  logic       misaligned;

  // The counter saturates so a stuck REQ can never wrap back below the limit.
  assign wait_next = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

`ifdef PC_ALIGN_CHECK_EN
  assign misaligned = (NextPC[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Handshake outputs are pure state decodes, so they drop the instant reset asserts.
  assign IMemReq    = (state == REQ);
  assign InstrValid = (state == VALID);
  assign IMemAddr   = CurrentPC;

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see the pre-edge values; blocking assignment would create order-dependent logic.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state     <= IDLE;
      CurrentPC <= '0;
      Instr     <= '0;
      Fault     <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          CurrentPC <= startPC;
          wait_cnt  <= '0;
          state     <= REQ;
        end
        REQ: begin
          // An acknowledge in the cycle the limit is reached still wins over the timeout.
          if (IMemAck) begin
            Instr <= IMemData;
            state <= VALID;
          end else begin
            wait_cnt <= wait_next;
            if (wait_next >= WAIT_LIMIT) begin
              Fault <= 1'b1;
              state <= HALT;
            end
          end
        end
        VALID: begin
          if (!Stall) begin
            if (misaligned) begin
              Fault <= 1'b1;
              state <= HALT;
            end else begin
              CurrentPC <= NextPC;
              wait_cnt  <= '0;
              state     <= REQ;
            end
          end
        end
        HALT: state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: a driver issues fetch transactions and queues the
// expected delivery; a monitor pops and checks each instruction the DUT presents.
module tb_pc_fetch_ctrl;

  localparam int MAX_WAIT = 4;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b1;
  logic [63:0] startPC = 64'h1000;
  logic [63:0] NextPC = '0;
  logic        Stall = 1'b0;
  logic        IMemAck = 1'b0;
  logic [31:0] IMemData = '0;
  logic [63:0] CurrentPC;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        Fault;

  pc_fetch_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .startPC(startPC), .NextPC(NextPC), .Stall(Stall),
    .IMemAck(IMemAck), .IMemData(IMemData), .CurrentPC(CurrentPC), .IMemReq(IMemReq),
    .IMemAddr(IMemAddr), .Instr(Instr), .InstrValid(InstrValid), .Fault(Fault)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] d;
    int          s;
    int          w;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model_pc;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (IMemReq) begin
        ok = 1'b1;
        return;
      end
      @(negedge CLK);
    end
    check("req_timeout", 64'(IMemReq), 64'd1);
  endtask

  // One fetch: ack after w empty REQ cycles, present d, stall s cycles, then offer np.
  task automatic fetch(input int w, input logic [31:0] d, input int s, input logic [63:0] np);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    check("req_addr", IMemAddr, model_pc);
    for (int i = 0; i < w; i++) begin
      IMemAck  = 1'b0;
      IMemData = $urandom;
      Stall    = 1'($urandom);
      NextPC   = {$urandom, $urandom};
      @(negedge CLK);
    end
    IMemAck  = 1'b1;
    IMemData = d;
    sb.push_back('{pc: model_pc, d: d, s: s, w: w});
    @(negedge CLK);
    for (int i = 0; i < s; i++) begin
      IMemAck  = 1'($urandom);
      IMemData = $urandom;
      Stall    = 1'b1;
      NextPC   = {$urandom, $urandom};
      @(negedge CLK);
    end
    IMemAck  = 1'($urandom);
    IMemData = $urandom;
    Stall    = 1'b0;
    NextPC   = np;
`ifdef PC_ALIGN_CHECK_EN
    if (np[1:0] == 2'b00) model_pc = np;
`else
    model_pc = np;
`endif
    @(negedge CLK);
    IMemAck = 1'b0;
  endtask

  task automatic do_reset(input logic [63:0] start);
    @(negedge CLK);
    #2 Reset_L = 1'b0;
    IMemAck = 1'b0;
    Stall   = 1'b0;
    startPC = start;
    model_pc = start;
    sb.delete();
    @(negedge CLK);
    @(negedge CLK);
    Reset_L = 1'b1;
  endtask

  // Monitor: pops one expectation per InstrValid rise and checks the whole VALID window.
  initial begin
    exp_t cur;
    bit   prev_valid = 1'b0;
    int   req_cycles = 0;
    int   valid_cycles = 0;
    cur = '{pc: '0, d: '0, s: 0, w: 0};
    forever begin
      @(negedge CLK);
      #1;
      if (!Reset_L) begin
        prev_valid   = 1'b0;
        req_cycles   = 0;
        valid_cycles = 0;
      end else begin
        if (IMemReq) req_cycles++;
        if (InstrValid && !prev_valid) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: got InstrValid=1 expected no delivery at %0t", $time);
          end else begin
            cur = sb.pop_front();
            check("ack_latency", 64'(req_cycles), 64'(cur.w + 1));
            check("valid_fault", 64'(Fault), 64'd0);
          end
          req_cycles   = 0;
          valid_cycles = 0;
        end
        if (InstrValid) begin
          valid_cycles++;
          check("instr", 64'(Instr), 64'(cur.d));
          check("valid_pc", CurrentPC, cur.pc);
        end
        if (!InstrValid && prev_valid)
          check("valid_len", 64'(valid_cycles), 64'(cur.s + 1));
        prev_valid = InstrValid;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] np;
    model_pc = 64'h1000;
    // Asynchronous reset, no clock edge involved.
    #3 Reset_L = 1'b0;
    #1;
    check("rst_pc", CurrentPC, 64'd0);
    check("rst_addr", IMemAddr, 64'd0);
    check("rst_req", 64'(IMemReq), 64'd0);
    check("rst_valid", 64'(InstrValid), 64'd0);
    check("rst_instr", 64'(Instr), 64'd0);
    check("rst_fault", 64'(Fault), 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    Reset_L = 1'b1;
    check("idle_req", 64'(IMemReq), 64'd0);
    check("idle_pc", CurrentPC, 64'd0);

    // Stall hold at 0x1000, then back-to-back zero-wait fetches.
    fetch(0, $urandom, 3, 64'h1004);
    for (int i = 0; i < 3; i++) fetch(0, $urandom, 0, model_pc + 64'd4);
    // Ack lands on the last allowed REQ cycle.
    fetch(MAX_WAIT - 1, $urandom, 0, model_pc + 64'd4);
    check("late_ack_fault", 64'(Fault), 64'd0);

    for (int i = 0; i < 40; i++) begin
      np = {$urandom, $urandom};
      np[1:0] = 2'b00;
      fetch($urandom_range(0, MAX_WAIT - 1), $urandom, $urandom_range(0, 4), np);
    end

    // Timeout: ack withheld for MAX_WAIT REQ cycles.
    do_reset(64'h2000);
    @(negedge CLK);
    for (int i = 0; i < MAX_WAIT - 1; i++) begin
      IMemAck  = 1'b0;
      IMemData = $urandom;
      Stall    = 1'($urandom);
      @(negedge CLK);
    end
    check("pre_timeout_req", 64'(IMemReq), 64'd1);
    check("pre_timeout_fault", 64'(Fault), 64'd0);
    @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      check("halt_fault", 64'(Fault), 64'd1);
      check("halt_req", 64'(IMemReq), 64'd0);
      check("halt_valid", 64'(InstrValid), 64'd0);
      check("halt_pc", CurrentPC, 64'h2000);
      check("halt_instr", 64'(Instr), 64'd0);
      IMemAck  = 1'b1;
      IMemData = $urandom;
      Stall    = 1'($urandom);
      NextPC   = {$urandom, $urandom};
      @(negedge CLK);
    end

    // Misaligned next PC.
    do_reset(64'h1000);
    fetch(0, $urandom, 0, 64'h1006);
`ifdef PC_ALIGN_CHECK_EN
    check("align_fault", 64'(Fault), 64'd1);
    check("align_pc", CurrentPC, 64'h1000);
    check("align_req", 64'(IMemReq), 64'd0);
`else
    check("align_fault", 64'(Fault), 64'd0);
    check("align_pc", CurrentPC, 64'h1006);
    check("align_req", 64'(IMemReq), 64'd1);
`endif

    // Asynchronous reset in the middle of a REQ.
    do_reset(64'h3000);
    fetch(0, $urandom, 0, 64'h3100);
    #2 Reset_L = 1'b0;
    #1;
    check("abort_pc", CurrentPC, 64'd0);
    check("abort_addr", IMemAddr, 64'd0);
    check("abort_req", 64'(IMemReq), 64'd0);
    check("abort_valid", 64'(InstrValid), 64'd0);
    check("abort_instr", 64'(Instr), 64'd0);
    check("abort_fault", 64'(Fault), 64'd0);
    IMemAck  = 1'b1;
    IMemData = $urandom;
    @(negedge CLK);
    @(negedge CLK);
    Reset_L  = 1'b1;
    IMemAck  = 1'b0;
    model_pc = 64'h3000;
    check("reidle_req", 64'(IMemReq), 64'd0);
    @(negedge CLK);
    check("rereq_req", 64'(IMemReq), 64'd1);
    check("rereq_pc", CurrentPC, 64'h3000);
    check("rereq_instr", 64'(Instr), 64'd0);
    fetch(1, $urandom, 1, 64'h3008);

    repeat (4) @(negedge CLK);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL provide parameter: MAX_WAIT, 15, cycles allowed in REQ without IMemAck before fault (legal 1..255).
REQ-002 SHALL provide port: CLK  input  1  sole clock, rising edge.
REQ-003 SHALL provide port: Reset_L  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port: startPC  input  64  PC loaded on leaving IDLE.
REQ-005 SHALL provide port: NextPC  input  64  next-PC value from the next-PC adder.
REQ-006 SHALL provide port: Stall  input  1  hold current instruction, no PC update.
REQ-007 SHALL provide port: IMemAck  input  1  instruction memory returns data this cycle.
REQ-008 SHALL provide port: IMemData  input  32  instruction word, valid when IMemAck=1.
REQ-009 SHALL provide port: CurrentPC  output  64  architectural PC, registered.
REQ-010 SHALL provide port: IMemReq  output  1  fetch request, combinational from state.
REQ-011 SHALL provide port: IMemAddr  output  64  equals CurrentPC.
REQ-012 SHALL provide port: Instr  output  32  latched instruction word.
REQ-013 SHALL provide port: InstrValid  output  1  Instr valid for execute.
REQ-014 SHALL provide port: Fault  output  1  sticky fetch fault.

Function
REQ-015 SHALL implement states IDLE, REQ, VALID, HALT in a single registered state variable.
REQ-016 IDLE SHALL last exactly one cycle after reset release: CurrentPC<=startPC, next state REQ.
REQ-017 REQ SHALL drive IMemReq=1, IMemAddr=CurrentPC; IMemAck=1 latches IMemData into Instr, next VALID; else stay REQ.
REQ-018 Latency SHALL be: IMemAck sampled at edge N -> InstrValid=1 in cycle after edge N; minimum fetch period 2 cycles.
REQ-019 VALID SHALL drive InstrValid=1, IMemReq=0; Stall=1 keeps VALID, CurrentPC and Instr unchanged.
REQ-020 VALID with Stall=0 SHALL load CurrentPC<=NextPC (all 64 bits, no modification), next REQ.
REQ-021 IMemAck outside REQ SHALL be ignored; Instr unchanged.
REQ-022 Wait counter SHALL clear on entering REQ, increment each REQ cycle without IMemAck, saturate; reaching MAX_WAIT SHALL set Fault=1, next HALT.
REQ-023 IMemAck in the same cycle the counter reaches MAX_WAIT SHALL take priority: no fault, go VALID.
REQ-024 HALT SHALL be terminal until reset: IMemReq=0, InstrValid=0, CurrentPC frozen, Fault=1.
REQ-025 Stall SHALL have no effect in IDLE, REQ, HALT.

Reset
REQ-026 Reset_L=0 SHALL asynchronously force: state IDLE, CurrentPC=0, Instr=0, InstrValid=0, IMemReq=0, Fault=0, wait counter 0.
REQ-027 Reset asserted mid-REQ or mid-VALID SHALL abandon the fetch; no partial Instr update after release.

Configuration
REQ-028 Macro PC_ALIGN_CHECK_EN defined: VALID with Stall=0 and NextPC[1:0]!=0 SHALL set Fault=1, leave CurrentPC unchanged, go HALT.
REQ-029 Macro PC_ALIGN_CHECK_EN undefined: NextPC SHALL load unconditionally; Fault set only by timeout.

Verification
REQ-030 Reset release, startPC=0x1000, IMemAck=1 always -> CurrentPC 0x1000, InstrValid every 2nd cycle, Instr=IMemData.
REQ-031 In VALID, NextPC=0x1004, Stall=1 for 3 cycles -> CurrentPC stays 0x1000, InstrValid high 4 cycles, then CurrentPC=0x1004.
REQ-032 IMemAck withheld, MAX_WAIT=4 -> Fault=1 after 4 REQ cycles, IMemReq=0, state held until Reset_L pulse.
REQ-033 IMemAck arrives on 4th REQ cycle with MAX_WAIT=4 -> no Fault, InstrValid next cycle.
REQ-034 PC_ALIGN_CHECK_EN defined, NextPC=0x1006 in VALID, Stall=0 -> Fault=1, CurrentPC remains 0x1000; undefined -> CurrentPC=0x1006.
REQ-035 Reset_L low asynchronously mid-REQ -> all outputs zero immediately, IDLE then REQ at startPC after release.
